// File: rtl/ip_pulse_led_indicator.sv
// Debug-pulse to WS2812 colour front end: latches VDP event strobes, serves them round-robin
// and holds each colour for HOLD_MS. Define IP_PULSE_LED_BLANK_EN to blank the LED when idle.
module ip_pulse_led_indicator #(
   parameter int         FREQ    = 85_909_080,
   parameter int         HOLD_MS = 100,
   parameter logic [7:0] BRIGHT  = 8'h20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pulse,
   input  logic       sending,
   output logic       wr,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic [2:0] active
);

   localparam int HOLD_CYC = FREQ / 1000 * HOLD_MS;
   localparam int CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
   localparam logic [7:0] HALF = BRIGHT >> 1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SEND = 3'd1;
   localparam logic [2:0] ST_ACK  = 3'd2;
   localparam logic [2:0] ST_BUSY = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;
`ifdef IP_PULSE_LED_BLANK_EN
   localparam logic [2:0] ST_OFF  = 3'd5;
`endif

   logic [2:0]       r_state;
   logic [7:0]       r_pending;
   logic [2:0]       r_active;
   logic             r_wr;
   logic [7:0]       r_red;
   logic [7:0]       r_green;
   logic [7:0]       r_blue;
   logic [1:0]       r_ack_cnt;
   logic [CNT_W-1:0] r_hold_cnt;
`ifdef IP_PULSE_LED_BLANK_EN
   logic             r_blank;
`endif

   logic             w_found;
   logic [2:0]       w_idx;
   logic [2:0]       w_grant_idx;
   logic             w_grant;
   logic [7:0]       w_clr;
   logic [2:0]       w_after_xfer;
   logic [2:0]       w_after_hold;

   function automatic logic [23:0] colour_of(input logic [2:0] ch);
      logic [23:0] rgb;
      case (ch)
         3'd0:    rgb = {BRIGHT, 8'h00,  8'h00};
         3'd1:    rgb = {8'h00,  BRIGHT, 8'h00};
         3'd2:    rgb = {8'h00,  8'h00,  BRIGHT};
         3'd3:    rgb = {BRIGHT, BRIGHT, 8'h00};
         3'd4:    rgb = {8'h00,  BRIGHT, BRIGHT};
         3'd5:    rgb = {BRIGHT, 8'h00,  BRIGHT};
         3'd6:    rgb = {BRIGHT, BRIGHT, BRIGHT};
         default: rgb = {BRIGHT, HALF,   8'h00};
      endcase
      return rgb;
   endfunction

   // Round-robin search from active+1; the channel just served is tried last (k = 8).
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_found     = 1'b0;
      w_grant_idx = r_active;
      w_idx       = r_active;
      for (int k = 1; k <= 8; k++) begin
         w_idx = r_active + 3'(k);
         if (!w_found && r_pending[w_idx]) begin
            w_found     = 1'b1;
            w_grant_idx = w_idx;
         end
      end
   end

   always_comb begin
      w_grant = (r_state == ST_IDLE) && w_found && !sending;
      w_clr   = '0;
      if (w_grant) w_clr[w_grant_idx] = 1'b1;
   end

   // Where a finished transfer and an expired hold lead; blanking writes skip the hold.
   always_comb begin
`ifdef IP_PULSE_LED_BLANK_EN
      w_after_xfer = r_blank ? ST_IDLE : ST_HOLD;
      w_after_hold = (r_pending == '0) ? ST_OFF : ST_IDLE;
`else
      w_after_xfer = ST_HOLD;
      w_after_hold = ST_IDLE;
`endif
   end

   // A fresh pulse beats the grant clear on the same bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_pending <= (r_pending & ~w_clr) | pulse;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_active   <= 3'd7;
         r_wr       <= 1'b0;
         r_red      <= '0;
         r_green    <= '0;
         r_blue     <= '0;
         r_ack_cnt  <= '0;
         r_hold_cnt <= '0;
`ifdef IP_PULSE_LED_BLANK_EN
         r_blank    <= 1'b0;
`endif
      end else begin
         r_wr <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_active                  <= w_grant_idx;
                  {r_red, r_green, r_blue}  <= colour_of(w_grant_idx);
                  r_wr                      <= 1'b1;
                  r_state                   <= ST_SEND;
`ifdef IP_PULSE_LED_BLANK_EN
                  r_blank                   <= 1'b0;
`endif
               end
            end
            ST_SEND: begin
               r_ack_cnt <= '0;
               r_state   <= ST_ACK;
            end
            ST_ACK: begin
               if (sending) begin
                  r_state <= ST_BUSY;
               end else if (r_ack_cnt == 2'd3) begin
                  r_hold_cnt <= HOLD_LOAD;
                  r_state    <= w_after_xfer;
               end else begin
                  r_ack_cnt <= r_ack_cnt + 2'd1;
               end
            end
            ST_BUSY: begin
               if (!sending) begin
                  r_hold_cnt <= HOLD_LOAD;
                  r_state    <= w_after_xfer;
               end
            end
            ST_HOLD: begin
               if (r_hold_cnt == '0) r_state <= w_after_hold;
               else                  r_hold_cnt <= r_hold_cnt - CNT_W'(1);
            end
`ifdef IP_PULSE_LED_BLANK_EN
            ST_OFF: begin
               if (!sending) begin
                  {r_red, r_green, r_blue} <= '0;
                  r_wr                     <= 1'b1;
                  r_blank                  <= 1'b1;
                  r_state                  <= ST_SEND;
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign wr     = r_wr;
   assign red    = r_red;
   assign green  = r_green;
   assign blue   = r_blue;
   assign active = r_active;

endmodule

// File: tb/tb_ip_pulse_led_indicator.sv
// Scoreboard bench for ip_pulse_led_indicator: stimulus queues expected colour writes,
// a monitor pops one per observed wr and checks colour, channel and cycle of arrival.
module tb_ip_pulse_led_indicator;

   logic       clk;
   logic       reset;
   logic [7:0] pulse;
   logic       sending;
   logic       wr;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic [2:0] active;

   logic tb_busy;
   logic drv_sending;
   logic drv_ack;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   k;
   int   w;
   int   j;

   typedef struct {
      logic [23:0] rgb;
      logic [2:0]  act;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic mon_prev_wr;
   logic mon_prev_send;

   assign sending = tb_busy | drv_sending;

   ip_pulse_led_indicator #(
      .FREQ    (1000),
      .HOLD_MS (16),
      .BRIGHT  (8'h20)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .pulse   (pulse),
      .sending (sending),
      .wr      (wr),
      .red     (red),
      .green   (green),
      .blue    (blue),
      .active  (active)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // All stimulus runs 2 time units after a rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   task automatic pulse_now(input logic [7:0] v);
      pulse = v;
      step();
      pulse = '0;
   endtask

   task automatic expect_wr(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [2:0] a, input int c);
      exp_t e;
      e.rgb = {r, g, b};
      e.act = a;
      e.cyc = c;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_wr", {31'b0, wr}, 32'd0);
      check("rst_rgb", {8'h00, red, green, blue}, 32'd0);
      check("rst_active", {29'b0, active}, 32'd7);
      step();
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (sb_q.size() != 0 && budget < 400) begin
         step();
         budget++;
      end
      repeat (40) step();
      check("drain_empty", sb_q.size(), 32'd0);
   endtask

   // LED driver model: raises sending one cycle after wr and keeps it high for five cycles.
   initial begin
      drv_sending = 1'b0;
      forever begin
         @(negedge clk);
         if (wr === 1'b1 && drv_ack) begin
            @(posedge clk);
            #2 drv_sending = 1'b1;
            repeat (5) @(posedge clk);
            #2 drv_sending = 1'b0;
         end
      end
   end

   initial begin
      mon_prev_wr   = 1'b0;
      mon_prev_send = 1'b0;
      forever begin
         @(negedge clk);
         if (wr === 1'b1) begin
            check("wr_one_cycle", {31'b0, mon_prev_wr}, 32'd0);
            check("wr_after_busy", {31'b0, mon_prev_send}, 32'd0);
            if (sb_q.size() == 0) begin
               check("spurious_wr", {31'b0, wr}, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check("wr_rgb", {8'h00, red, green, blue}, {8'h00, mon_e.rgb});
               check("wr_active", {29'b0, active}, {29'b0, mon_e.act});
               check("wr_cycle", cyc, mon_e.cyc);
            end
         end
         mon_prev_wr   = (wr === 1'b1);
         mon_prev_send = sending;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      pulse   = '0;
      tb_busy = 1'b0;
      drv_ack = 1'b1;
      repeat (3) step();
      do_reset();

      // Single event with re-pulse of the held channel alongside ch5: ch5 goes first.
      k = cyc;
      w = k + 2;
      expect_wr(8'h00, 8'h00, 8'h20, 3'd2, w);
      pulse_now(8'h04);
      wait_until(w + 10);
      expect_wr(8'h20, 8'h00, 8'h20, 3'd5, w + 24);
      expect_wr(8'h00, 8'h00, 8'h20, 3'd2, w + 48);
`ifdef IP_PULSE_LED_BLANK_EN
      expect_wr(8'h00, 8'h00, 8'h00, 3'd2, w + 72);
`endif
      pulse_now(8'h24);
      drain();

      // Two simultaneous events: ch0 then ch7 after the hold.
      do_reset();
      k = cyc;
      expect_wr(8'h20, 8'h00, 8'h00, 3'd0, k + 2);
      expect_wr(8'h20, 8'h10, 8'h00, 3'd7, k + 26);
`ifdef IP_PULSE_LED_BLANK_EN
      expect_wr(8'h00, 8'h00, 8'h00, 3'd7, k + 50);
`endif
      pulse_now(8'h81);
      drain();

      // Driver busy before the pulse: wr waits for sending to fall.
      do_reset();
      tb_busy = 1'b1;
      step();
      k = cyc;
      j = k + 6;
      expect_wr(8'h00, 8'h20, 8'h00, 3'd1, j + 1);
`ifdef IP_PULSE_LED_BLANK_EN
      expect_wr(8'h00, 8'h00, 8'h00, 3'd1, j + 25);
`endif
      pulse_now(8'h02);
      wait_until(j);
      tb_busy = 1'b0;
      drain();

      // Driver never acknowledges: ACK times out, hold still runs, next event is served.
      do_reset();
      drv_ack = 1'b0;
      k = cyc;
      w = k + 2;
      expect_wr(8'h20, 8'h20, 8'h00, 3'd3, w);
      expect_wr(8'h00, 8'h20, 8'h20, 3'd4, w + 22);
`ifdef IP_PULSE_LED_BLANK_EN
      expect_wr(8'h00, 8'h00, 8'h00, 3'd4, w + 44);
`endif
      pulse_now(8'h08);
      wait_until(w + 3);
      pulse_now(8'h10);
      drain();
      drv_ack = 1'b1;

      // Lone event on ch6: blanking write only with the macro.
      do_reset();
      k = cyc;
      expect_wr(8'h20, 8'h20, 8'h20, 3'd6, k + 2);
`ifdef IP_PULSE_LED_BLANK_EN
      expect_wr(8'h00, 8'h00, 8'h00, 3'd6, k + 26);
`endif
      pulse_now(8'h40);
      drain();

      // Reset while BUSY with ch2 pending: nothing is written until a new pulse.
      do_reset();
      k = cyc;
      w = k + 2;
      expect_wr(8'h20, 8'h00, 8'h20, 3'd5, w);
      pulse_now(8'h20);
      wait_until(w + 2);
      pulse_now(8'h04);
      do_reset();
      repeat (60) step();
      k = cyc;
      expect_wr(8'h20, 8'h00, 8'h00, 3'd0, k + 2);
`ifdef IP_PULSE_LED_BLANK_EN
      expect_wr(8'h00, 8'h00, 8'h00, 3'd0, k + 26);
`endif
      pulse_now(8'h01);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ip_pulse_led_indicator.md
# ip_pulse_led_indicator

Event-to-colour front end for the WS2812 debug LED driver. It captures single-cycle debug pulses from the VDP, arbitrates among them round-robin, and issues colour write requests to the LED driver over its `wr`/`sending` handshake. Each colour is held visible for a fixed time. It sits between the VDP debug pulse outputs and `ip_ws2812_led`, in the `clk85m` domain.

## Interface
Parameters:
- `FREQ`, default 85_909_080: clock frequency in Hz.
- `HOLD_MS`, default 100: minimum display time per event, in ms.
- `BRIGHT`, default 8'h20: full-channel intensity.

Ports:
- `clk`, in, 1: system clock (`clk85m`).
- `reset`, in, 1: reset. One clock; reset is synchronous and active-high.
- `pulse`, in, 8: debug event strobes. A bit is one cycle high per event.
- `sending`, in, 1: LED driver busy.
- `wr`, out, 1: colour write strobe, one cycle wide.
- `red`, out, 8: colour value presented with `wr`.
- `green`, out, 8: colour value presented with `wr`.
- `blue`, out, 8: colour value presented with `wr`.
- `active`, out, 3: index of the channel last served.

## Operation
- **Pending latch**
  - `pending[i]` is set by `pulse[i]` and cleared when channel i is granted.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- **Colour table**, with B = `BRIGHT` and H = `BRIGHT>>1`, given as (R,G,B):
  - ch0 (B,0,0), ch1 (0,B,0), ch2 (0,0,B), ch3 (B,B,0)
  - ch4 (0,B,B), ch5 (B,0,B), ch6 (B,B,B), ch7 (B,H,0)
- **Arbiter**: round-robin. The search starts at `active+1` and wraps 7→0.
- **State machine**
  - IDLE: if `pending != 0` and `sending == 0`, grant the channel, load the colour, go to SEND.
  - SEND: `wr = 1` for one cycle. Go to ACK.
  - ACK: wait for `sending == 1`, then go to BUSY. If `sending` is not seen within 4 cycles, go straight to HOLD.
  - BUSY: wait for `sending == 0`. Load the hold counter with `FREQ/1000*HOLD_MS - 1`. Go to HOLD.
  - HOLD: decrement the counter. At 0, go to IDLE, or to OFF (see Configuration).
  - OFF: only exists with the macro. Send black via the same SEND/ACK/BUSY path without hold, then return to IDLE.
- **Output hold**: `red`/`green`/`blue` stay stable from SEND until the next SEND.
- **Reset values**: `wr = 0`, `red`/`green`/`blue` = 0, `active = 7`, `pending = 0`, state IDLE. Reset mid-transfer aborts immediately and no `wr` is issued afterwards.
- **Re-pulse during service**: a pulse on the channel currently in HOLD re-sets its pending bit. That channel is served again only after the other pending channels.

## Timing
- Pulse at cycle N → `pending` set at N+1 → grant in IDLE at N+1 → `wr` high at N+2, when `sending` is 0.
- `wr` is never asserted while `sending == 1` was sampled in the previous cycle.
- Minimum spacing between two grants = handshake time + hold cycles.
- All outputs are registered. No combinational path runs from `pulse` or `sending` to any output.

## Configuration
- **`IP_PULSE_LED_BLANK_EN` defined**:
  - When HOLD expires with `pending == 0`, go to OFF and send (0,0,0) once.
  - If `pending != 0` at expiry, go to IDLE and serve the next event without blanking.
- **Undefined**:
  - OFF state is absent.
  - HOLD always returns to IDLE.
  - The last colour remains on the LED.

## Test plan
All scenarios use `FREQ=1000` and `HOLD_MS=16`, giving 16 hold cycles.
1. Reset low, `pulse = 8'h04` at cycle 10, driver model asserts `sending` for 5 cycles → `wr` at cycle 12 with (0,0,0x20), `active = 2`, next `wr` no earlier than end of busy + 16 cycles.
2. `pulse = 8'h81` in the same cycle → ch0 (0x20,0,0) served first, then ch7 (0x20,0x10,0) after hold. Each gets exactly one `wr`.
3. `sending` held high before a pulse on ch1 → `wr` stays low until `sending` falls, then `wr` in the next IDLE→SEND.
4. Driver never raises `sending` → ACK times out after 4 cycles, HOLD runs 16 cycles, no lockup.
5. With `IP_PULSE_LED_BLANK_EN`, a single pulse on ch6 → (0x20,0x20,0x20) `wr`, then after hold a (0,0,0) `wr`. Without the macro, only one `wr`.
6. Assert `reset` during BUSY → next cycle `wr = 0`, rgb = 0, `pending = 0`. No `wr` until a new pulse.
